// File: rtl/burst_mac_arbiter.sv
// Round-robin arbiter for NUM_CH requesters onto one async memory bus.
// Each grant runs a 1..2^BURST_W beat burst with per-beat ack timeout.
module burst_mac_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int BURST_W = 4,
  parameter int TIMEOUT = 16,
  parameter int CH_W    = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH-1:0]          req_mr,
  input  logic [NUM_CH-1:0]          req_mw,
  input  logic [NUM_CH*BURST_W-1:0]  req_len,
  input  logic                       ack_n,
  output logic                       as_n,
  output logic                       wr_n,
  output logic                       stop_n,
  output logic [NUM_CH-1:0]          grant,
  output logic [NUM_CH-1:0]          beat_done,
  output logic [NUM_CH-1:0]          xfer_done,
  output logic [NUM_CH-1:0]          xfer_err,
  output logic [1:0]                 sm_state,
  output logic [CH_W-1:0]            cur_ch,
  output logic [BURST_W-1:0]         beat_cnt,
  output logic                       in_init,
  output logic                       busy
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    WAIT = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     cur_q, cur_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic                wr_q, wr_d;
  logic                err_q, err_d;
  logic [BURST_W-1:0]  len_q, len_d;
  logic [BURST_W-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                beat_q, beat_d;

  logic [NUM_CH-1:0]   pend;
  logic                found;
  logic [CH_W-1:0]     pick;
  logic [CH_W-1:0]     scan;
  logic [BURST_W-1:0]  len_sel;
  logic [NUM_CH-1:0]   own;

  assign pend    = req_mr | req_mw;
  assign len_sel = req_len[pick*BURST_W +: BURST_W];

  // Round-robin search: first pending channel after last owner, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = last_q;
    for (int i = 0; i < NUM_CH; i++) begin
      scan = (scan == CH_W'(NUM_CH - 1)) ? '0 : scan + CH_W'(1);
      if (!found && pend[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= CH_W'(NUM_CH - 1);
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      beat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state and datapath update; ack only matters in WAIT.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    wr_d    = wr_q;
    err_d   = err_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    beat_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          cur_d   = pick;
          wr_d    = req_mw[pick];
          len_d   = len_sel;
          cnt_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
          state_d = INIT;
        end
      end
      INIT: state_d = WAIT;
      WAIT: begin
        if (!ack_n) begin
          beat_d = 1'b1;
          tmo_d  = '0;
          if (cnt_q == len_q) begin
            err_d   = 1'b0;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + BURST_W'(1);
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = STOP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      STOP: begin
        last_d  = cur_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    own          = '0;
    own[cur_q]   = 1'b1;
    busy         = (state_q != IDLE);
    in_init      = (state_q == INIT);
    as_n         = !(state_q == INIT || state_q == WAIT);
    wr_n         = !((state_q == INIT || state_q == WAIT) && wr_q);
    stop_n       = (state_q != STOP);
    grant        = busy ? own : '0;
    beat_done    = beat_q ? own : '0;
    xfer_done    = (state_q == STOP && !err_q) ? own : '0;
    xfer_err     = (state_q == STOP && err_q) ? own : '0;
    sm_state     = state_q;
    cur_ch       = cur_q;
    beat_cnt     = cnt_q;
  end

endmodule

// File: tb/tb_burst_mac_arbiter.sv
// Directed self-checking bench for burst_mac_arbiter.
// Completion scoreboard plus grant-order queue.
module tb_burst_mac_arbiter;

  localparam int NUM_CH  = 4;
  localparam int BURST_W = 4;
  localparam int TIMEOUT = 16;
  localparam int CH_W    = 2;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_CH-1:0]         req_mr;
  logic [NUM_CH-1:0]         req_mw;
  logic [NUM_CH*BURST_W-1:0] req_len;
  logic                      ack_n;
  logic                      as_n;
  logic                      wr_n;
  logic                      stop_n;
  logic [NUM_CH-1:0]         grant;
  logic [NUM_CH-1:0]         beat_done;
  logic [NUM_CH-1:0]         xfer_done;
  logic [NUM_CH-1:0]         xfer_err;
  logic [1:0]                sm_state;
  logic [CH_W-1:0]           cur_ch;
  logic [BURST_W-1:0]        beat_cnt;
  logic                      in_init;
  logic                      busy;

  burst_mac_arbiter #(
    .NUM_CH(NUM_CH), .BURST_W(BURST_W),
    .TIMEOUT(TIMEOUT), .CH_W(CH_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_mr(req_mr), .req_mw(req_mw),
    .req_len(req_len), .ack_n(ack_n),
    .as_n(as_n), .wr_n(wr_n), .stop_n(stop_n),
    .grant(grant), .beat_done(beat_done),
    .xfer_done(xfer_done), .xfer_err(xfer_err),
    .sm_state(sm_state), .cur_ch(cur_ch),
    .beat_cnt(beat_cnt), .in_init(in_init),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    bit err;
  } exp_t;

  exp_t sb[$];
  int   gq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset();
    chk("rst_state", 32'(sm_state), 0);
    chk("rst_as_n", 32'(as_n), 1);
    chk("rst_wr_n", 32'(wr_n), 1);
    chk("rst_stop_n", 32'(stop_n), 1);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_beat", 32'(beat_done), 0);
    chk("rst_done", 32'(xfer_done), 0);
    chk("rst_err", 32'(xfer_err), 0);
    chk("rst_cur", 32'(cur_ch), 0);
    chk("rst_cnt", 32'(beat_cnt), 0);
    chk("rst_init", 32'(in_init), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  // Step until STOP, then pop the expected completion and compare.
  task automatic wait_stop(input int budget, output int n);
    bit   seen;
    exp_t e;
    n    = 0;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (stop_n === 1'b0) seen = 1;
      else n++;
    end
    chk("stop_seen", 32'(seen), 1);
    chk("sb_nonempty", 32'(sb.size() != 0), 1);
    if (seen && sb.size() != 0) begin
      e = sb.pop_front();
      chk("stop_grant", 32'(grant), 32'(1) << e.ch);
      chk("stop_done", 32'(xfer_done),
          e.err ? 0 : 32'(1) << e.ch);
      chk("stop_err", 32'(xfer_err),
          e.err ? 32'(1) << e.ch : 0);
      chk("stop_as_n", 32'(as_n), 1);
      chk("stop_wr_n", 32'(wr_n), 1);
    end
  endtask

  initial begin
    int n;
    int beats;
    int inits;
    int prev;
    int g;
    bit idle_seen;

    reset_n = 1'b0;
    req_mr  = '0;
    req_mw  = '0;
    req_len = '0;
    ack_n   = 1'b1;
    step();
    step();
    chk_reset();

    // single write beat on ch0, ack two cycles after INIT
    reset_n   = 1'b1;
    req_mw[0] = 1'b1;
    step();
    chk("t1_init", 32'(in_init), 1);
    chk("t1_as_n0", 32'(as_n), 0);
    chk("t1_wr_n0", 32'(wr_n), 0);
    chk("t1_grant", 32'(grant), 1);
    sb.push_back('{ch: 0, err: 0});
    step();
    chk("t1_as_n1", 32'(as_n), 0);
    chk("t1_wait", 32'(sm_state), 2);
    step();
    chk("t1_as_n2", 32'(as_n), 0);
    chk("t1_wr_n2", 32'(wr_n), 0);
    ack_n = 1'b0;
    wait_stop(5, n);
    chk("t1_beat", 32'(beat_done), 1);
    ack_n     = 1'b1;
    req_mw[0] = 1'b0;
    step();
    chk("t1_busy", 32'(busy), 0);
    chk("t1_done_clr", 32'(xfer_done), 0);
    chk("t1_beat_clr", 32'(beat_done), 0);

    // 4-beat read burst on ch2 with ack held low
    req_mr[2]       = 1'b1;
    req_len[8 +: 4] = 4'd3;
    ack_n           = 1'b0;
    step();
    chk("t2_grant", 32'(grant), 4);
    chk("t2_wr_n", 32'(wr_n), 1);
    sb.push_back('{ch: 2, err: 0});
    beats = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_cnt", 32'(beat_cnt), 32'(i));
      chk("t2_wr_n_w", 32'(wr_n), 1);
      if (beat_done === 4'b0100) beats++;
    end
    wait_stop(3, n);
    if (beat_done === 4'b0100) beats++;
    chk("t2_cnt_sat", 32'(beat_cnt), 3);
    chk("t2_beats", 32'(beats), 4);
    req_mr[2] = 1'b0;
    ack_n     = 1'b1;
    step();

    // round robin from reset, all channels, immediate ack
    reset_n = 1'b0;
    step();
    reset_n         = 1'b1;
    req_len         = '0;
    req_mr          = 4'hF;
    ack_n           = 1'b0;
    gq              = '{0, 1, 2, 3, 0};
    inits           = 0;
    prev            = 0;
    for (int i = 0; i < 40 && inits < 5; i++) begin
      step();
      if (in_init === 1'b1) begin
        g = gq.pop_front();
        chk("t3_grant", 32'(grant), 32'(1) << g);
        chk("t3_wr_n", 32'(wr_n), 1);
        if (inits > 0) chk("t3_period", 32'(cyc - prev), 4);
        prev = cyc;
        inits++;
      end
    end
    chk("t3_inits", 32'(inits), 5);
    req_mr    = '0;
    idle_seen = 0;
    for (int i = 0; i < 10 && !idle_seen; i++) begin
      step();
      if (busy === 1'b0) idle_seen = 1;
    end
    chk("t3_idle", 32'(idle_seen), 1);
    ack_n = 1'b1;

    // read and write both set: write wins
    req_mr[1] = 1'b1;
    req_mw[1] = 1'b1;
    step();
    chk("t4_grant", 32'(grant), 2);
    chk("t4_wr_n", 32'(wr_n), 0);
    sb.push_back('{ch: 1, err: 0});
    ack_n = 1'b0;
    wait_stop(5, n);
    req_mr = '0;
    req_mw = '0;
    ack_n  = 1'b1;
    step();

    // timeout on ch1, then ch2 wins over ch0
    req_mr[1] = 1'b1;
    step();
    chk("t5_grant", 32'(grant), 2);
    sb.push_back('{ch: 1, err: 1});
    wait_stop(40, n);
    chk("t5_waits", 32'(n), 16);
    req_mr          = 4'b0101;
    req_len[8 +: 4] = 4'd3;
    step();
    chk("t5_idle", 32'(sm_state), 0);
    step();
    chk("t5_next", 32'(grant), 4);

    // reset in the middle of a burst
    step();
    ack_n = 1'b0;
    step();
    chk("t6_cnt", 32'(beat_cnt), 1);
    reset_n = 1'b0;
    ack_n   = 1'b1;
    step();
    chk_reset();
    reset_n = 1'b1;
    step();
    chk("t6_grant", 32'(grant), 1);
    req_mr = '0;
    chk("sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
